// File: rtl/mult_share_sequencer.sv
// Round-robin sequencer sharing one fixed-latency array multiplier
// between two requesters, with a valid/ready response channel.
module mult_share_sequencer #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_p,
    output logic               rsp_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preload: the capture edge is MUL_LAT edges after accept.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               prio_q, prio_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d;
    logic               rsp_id_q, rsp_id_d;
    logic               gnt0, gnt1;

    // Grant decode: priority holder wins a tie, a lone requester always wins.
    always_comb begin
        gnt0 = (state_q == IDLE) && req0_valid && (!prio_q || !req1_valid);
        gnt1 = (state_q == IDLE) && req1_valid && (prio_q || !req0_valid);
    end

    // Next-state and datapath load logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        rsp_p_d  = rsp_p_q;
        rsp_id_d = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0) begin
                    mul_a_d  = req0_a;
                    mul_b_d  = req0_b;
                    rsp_id_d = 1'b0;
                    prio_d   = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = CALC;
                end else if (gnt1) begin
                    mul_a_d  = req1_a;
                    mul_b_d  = req1_b;
                    rsp_id_d = 1'b1;
                    prio_d   = 1'b0;
                    cnt_d    = CNT_INIT;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q == 4'd0) begin
                    rsp_p_d = mul_p;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            prio_q   <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rsp_p_q  <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rsp_p_q  <= rsp_p_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    // Output drive.
    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        mul_a      = mul_a_q;
        mul_b      = mul_b_q;
        rsp_valid  = (state_q == RESP);
        rsp_p      = rsp_p_q;
        rsp_id     = rsp_id_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mult_share_sequencer.sv
// Self-checking bench: three sequencers (latency 2, 1, 4), each with
// its own pipelined multiplier model and a transaction-level reference.
module tb_mult_share_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v0 [3];
    logic [7:0]  a0 [3];
    logic [7:0]  b0 [3];
    logic        r0 [3];
    logic        v1 [3];
    logic [7:0]  a1 [3];
    logic [7:0]  b1 [3];
    logic        r1 [3];
    logic [7:0]  ma [3];
    logic [7:0]  mb [3];
    logic [15:0] mp [3];
    logic        rv [3];
    logic        rr [3];
    logic [15:0] rp [3];
    logic        rid [3];
    logic        bsy [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_prio [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 4;
        logic [15:0] pipe [4];
        always @(posedge clk) begin
            pipe[0] <= 16'(ma[k]) * 16'(mb[k]);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mp[k] = (L == 1) ? 16'(ma[k]) * 16'(mb[k])
                                : pipe[(L >= 2) ? L - 2 : 0];
        mult_share_sequencer #(.WIDTH(8), .MUL_LAT(L)) dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0[k]), .req0_a(a0[k]), .req0_b(b0[k]),
            .req0_ready(r0[k]),
            .req1_valid(v1[k]), .req1_a(a1[k]), .req1_b(b1[k]),
            .req1_ready(r1[k]),
            .mul_a(ma[k]), .mul_b(mb[k]), .mul_p(mp[k]),
            .rsp_valid(rv[k]), .rsp_ready(rr[k]),
            .rsp_p(rp[k]), .rsp_id(rid[k]), .busy(bsy[k])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) exp_prio[k] = 0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic idle_in(int k);
        v0[k] = 1'b0;
        v1[k] = 1'b0;
        rr[k] = 1'b0;
    endtask

    // One transaction from an IDLE cycle; returns accept cycle (-1 if none).
    task automatic txn(int k, logic q0, logic [7:0] x0, logic [7:0] y0,
                       logic q1, logic [7:0] x1, logic [7:0] y1,
                       int stall, output int acc);
        int gi;
        int n;
        logic [15:0] ep;
        logic [15:0] held_p;
        logic held_id;
        acc = -1;
        v0[k] = q0; a0[k] = x0; b0[k] = y0;
        v1[k] = q1; a1[k] = x1; b1[k] = y1;
        rr[k] = 1'($urandom_range(0, 1));
        #1;
        if (q0 && (exp_prio[k] == 0 || !q1)) gi = 0;
        else if (q1) gi = 1;
        else gi = -1;
        chk("req0_ready", 32'(r0[k]), 32'(gi == 0));
        chk("req1_ready", 32'(r1[k]), 32'(gi == 1));
        if (gi < 0) return;
        ep = (gi == 0) ? 16'(x0) * 16'(y0) : 16'(x1) * 16'(y1);
        exp_prio[k] = 1 - gi;
        @(posedge clk);
        acc = cyc;
        #1;
        a0[k] = 8'($urandom); b0[k] = 8'($urandom);
        a1[k] = 8'($urandom); b1[k] = 8'($urandom);
        v0[k] = 1'($urandom_range(0, 1));
        v1[k] = 1'($urandom_range(0, 1));
        n = 0;
        while (!rv[k] && n <= 20) begin
            chk("busy_calc", 32'(bsy[k]), 32'd1);
            chk("rdy_calc", 32'({r0[k], r1[k]}), 32'd0);
            rr[k] = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(lat_of(k)));
        chk("rsp_p", 32'(rp[k]), 32'(ep));
        chk("rsp_id", 32'(rid[k]), 32'(gi));
        held_p = rp[k];
        held_id = rid[k];
        v0[k] = 1'b1;
        v1[k] = 1'b1;
        rr[k] = 1'b0;
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", 32'(rv[k]), 32'd1);
            chk("stall_p", 32'(rp[k]), 32'(held_p));
            chk("stall_id", 32'(rid[k]), 32'(held_id));
            chk("stall_rdy", 32'({r0[k], r1[k]}), 32'd0);
            chk("stall_busy", 32'(bsy[k]), 32'd1);
        end
        rr[k] = 1'b1;
        step();
        rr[k] = 1'b0;
        chk("post_hs_valid", 32'(rv[k]), 32'd0);
        chk("post_hs_busy", 32'(bsy[k]), 32'd0);
    endtask

    initial begin
        int acc;
        int prev;
        logic q0;
        logic q1;
        for (int k = 0; k < 3; k++) begin
            idle_in(k);
            a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
        end

        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", 32'(rv[k]), 32'd0);
            chk("rst_busy", 32'(bsy[k]), 32'd0);
            chk("rst_mul", 32'({ma[k], mb[k]}), 32'd0);
            chk("rst_rsp", 32'({rp[k], rid[k]}), 32'd0);
        end
        do_reset();

        // Simultaneous requests, then strict alternation.
        txn(0, 1, 8'd3, 8'd5, 1, 8'd7, 8'd9, 0, acc);
        txn(0, 1, 8'd3, 8'd5, 1, 8'd7, 8'd9, 0, acc);
        for (int i = 0; i < 6; i++)
            txn(0, 1, 8'($urandom), 8'($urandom),
                   1, 8'($urandom), 8'($urandom), 0, acc);

        // Single max-operand request with backpressure.
        txn(0, 1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 10, acc);

        // Lone requester 1, back-to-back.
        txn(0, 1, 8'($urandom), 8'($urandom), 0, 8'h00, 8'h00, 0, prev);
        for (int i = 0; i < 4; i++) begin
            txn(0, 0, 8'h00, 8'h00, 1, 8'($urandom), 8'($urandom), 0, acc);
            chk("issue_interval", 32'(acc - prev), 32'(lat_of(0) + 2));
            prev = acc;
        end

        // Random mix.
        for (int i = 0; i < 20; i++) begin
            q0 = 1'($urandom_range(0, 1));
            q1 = (!q0) ? 1'b1 : 1'($urandom_range(0, 1));
            txn(0, q0, 8'($urandom), 8'($urandom),
                   q1, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), acc);
        end

        // Reset during CALC.
        v0[0] = 1'b1; a0[0] = 8'h12; b0[0] = 8'h34;
        v1[0] = 1'b0;
        step();
        v0[0] = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bsy[0]), 32'd0);
        chk("arst_valid", 32'(rv[0]), 32'd0);
        chk("arst_mul_a", 32'(ma[0]), 32'd0);
        for (int k = 0; k < 3; k++) exp_prio[k] = 0;
        step();
        rst = 1'b0;
        rr[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("no_rsp_after_rst", 32'({rv[0], bsy[0]}), 32'd0);
        end
        rr[0] = 1'b0;
        txn(0, 1, 8'($urandom), 8'($urandom),
               1, 8'($urandom), 8'($urandom), 0, acc);
        idle_in(0);

        // Operand stability on latency 1 and 4.
        for (int k = 1; k < 3; k++) begin
            txn(k, 1, 8'h80, 8'h02, 0, 8'h00, 8'h00, 0, acc);
            for (int i = 0; i < 6; i++) begin
                q0 = 1'($urandom_range(0, 1));
                q1 = (!q0) ? 1'b1 : 1'($urandom_range(0, 1));
                txn(k, q0, 8'($urandom), 8'($urandom),
                       q1, 8'($urandom), 8'($urandom),
                       int'($urandom_range(0, 2)), acc);
            end
            idle_in(k);
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
